cdb_arbiter: RTL

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_if.sv | 37 +++
 rtl/cdb_arbiter.sv | 124 ++++++++++++
 2 files changed

// File: rtl/cdb_arbiter_if.sv
// Bundle of control, producer-push and common-data-bus signals around cdb_arbiter.
// master drives rdy/rollback and pushes; slave is the arbiter.
interface cdb_arbiter_if #(
  parameter int TAG_W = 4
);
  logic             rdy;
  logic             rollback;
  logic             alu_valid;
  logic [31:0]      alu_result;
  logic [TAG_W-1:0] alu_tag;
  logic             lsb_valid;
  logic [31:0]      lsb_result;
  logic [TAG_W-1:0] lsb_tag;
  logic             alu_full;
  logic             lsb_full;
  logic             cdb_valid;
  logic [31:0]      cdb_result;
  logic [TAG_W-1:0] cdb_tag;
  logic             cdb_src;
  logic             overflow_err;

  modport master (
    output rdy, rollback,
    output alu_valid, alu_result, alu_tag,
    output lsb_valid, lsb_result, lsb_tag,
    input  alu_full, lsb_full,
    input  cdb_valid, cdb_result, cdb_tag, cdb_src, overflow_err
  );

  modport slave (
    input  rdy, rollback,
    input  alu_valid, alu_result, alu_tag,
    input  lsb_valid, lsb_result, lsb_tag,
    output alu_full, lsb_full,
    output cdb_valid, cdb_result, cdb_tag, cdb_src, overflow_err
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source circular FIFOs (0 = ALU, 1 = LSB) drained
// one entry per cycle onto a registered broadcast, round-robin between sources.
module cdb_arbiter #(
  parameter int TAG_W = 4,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  cdb_arbiter_if.slave  bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [1:0]       src_valid;
  logic [31:0]      src_result [2];
  logic [TAG_W-1:0] src_tag    [2];
  logic [31:0]      head_result [2];
  logic [TAG_W-1:0] head_tag    [2];
  logic [1:0]       full;
  logic [1:0]       nonempty;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic             active;
  logic             grant_lsb;

  logic             last_grant_reg;
  logic             cdb_valid_reg;
  logic [31:0]      cdb_result_reg;
  logic [TAG_W-1:0] cdb_tag_reg;
  logic             cdb_src_reg;
  logic             overflow_err_reg;

  assign src_valid     = {bus.lsb_valid, bus.alu_valid};
  assign src_result[0] = bus.alu_result;
  assign src_result[1] = bus.lsb_result;
  assign src_tag[0]    = bus.alu_tag;
  assign src_tag[1]    = bus.lsb_tag;

  // A rollback edge neither accepts pushes nor pops heads.
  assign active = bus.rdy && !bus.rollback;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [31:0]      mem_result [DEPTH];
      logic [TAG_W-1:0] mem_tag    [DEPTH];
      logic [PTR_W-1:0] rd_ptr_reg;
      logic [PTR_W-1:0] wr_ptr_reg;
      logic [CNT_W-1:0] count_reg;

      assign full[gi]        = (count_reg == CNT_W'(DEPTH));
      assign nonempty[gi]    = (count_reg != '0);
      assign push[gi]        = active && src_valid[gi] && !full[gi];
      assign head_result[gi] = mem_result[rd_ptr_reg];
      assign head_tag[gi]    = mem_tag[rd_ptr_reg];

      // Storage needs no reset: pointers and count define what is live.
      always_ff @(posedge clk) begin
        if (push[gi]) begin
          mem_result[wr_ptr_reg] <= src_result[gi];
          mem_tag[wr_ptr_reg]    <= src_tag[gi];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          rd_ptr_reg <= '0;
          wr_ptr_reg <= '0;
          count_reg  <= '0;
        end else if (bus.rdy) begin
          if (bus.rollback) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
          end else begin
            if (push[gi]) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop[gi])  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_reg + CNT_W'(push[gi]) - CNT_W'(pop[gi]);
          end
        end
      end
    end
  endgenerate

  // With both sources waiting, the one that did not win last time goes next.
  assign grant_lsb = (nonempty == 2'b11) ? !last_grant_reg : nonempty[1];
  assign pop[0]    = active && nonempty[0] && !grant_lsb;
  assign pop[1]    = active && nonempty[1] && grant_lsb;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg   <= 1'b1;
      cdb_valid_reg    <= 1'b0;
      cdb_result_reg   <= '0;
      cdb_tag_reg      <= '0;
      cdb_src_reg      <= 1'b0;
      overflow_err_reg <= 1'b0;
    end else if (bus.rdy) begin
      if (bus.rollback) begin
        last_grant_reg <= 1'b1;
        cdb_valid_reg  <= 1'b0;
      end else begin
        if (|(src_valid & full)) overflow_err_reg <= 1'b1;
        if (|nonempty) begin
          cdb_valid_reg  <= 1'b1;
          cdb_result_reg <= grant_lsb ? head_result[1] : head_result[0];
          cdb_tag_reg    <= grant_lsb ? head_tag[1] : head_tag[0];
          cdb_src_reg    <= grant_lsb;
          last_grant_reg <= grant_lsb;
        end else begin
          cdb_valid_reg <= 1'b0;
        end
      end
    end
  end

  assign bus.alu_full     = full[0];
  assign bus.lsb_full     = full[1];
  assign bus.cdb_valid    = cdb_valid_reg;
  assign bus.cdb_result   = cdb_result_reg;
  assign bus.cdb_tag      = cdb_tag_reg;
  assign bus.cdb_src      = cdb_src_reg;
  assign bus.overflow_err = overflow_err_reg;
endmodule
